// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: per-pin direction, atomic set/clear,
// synchronised inputs with edge detection, W1C status and a level interrupt.
module gpio_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              we,
  input  logic              re,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio_out,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

  typedef enum logic [2:0] {
    REG_IN       = 3'd0,
    REG_OUT      = 3'd1,
    REG_DIR      = 3'd2,
    REG_SET      = 3'd3,
    REG_CLR      = 3'd4,
    REG_IRQ_EN   = 3'd5,
    REG_IRQ_POL  = 3'd6,
    REG_IRQ_STAT = 3'd7
  } reg_e;

  reg_e             reg_idx;
  logic             mapped;
  logic             wr_en;
  logic             rd_en;
  logic [31:0]      lane_mask;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wbits;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] en_q;
  logic [WIDTH-1:0] pol_q;
  logic [WIDTH-1:0] stat_q;
  logic [WIDTH-1:0] stat_clr;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] prev_in;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] rd_val;

  // Any address bit above the 8-word window marks the access as unmapped.
  assign reg_idx   = reg_e'(addr[4:2]);
  assign mapped    = (addr >> 5) == '0;
  assign wr_en     = sel & we & mapped;
  assign rd_en     = sel & re & ~we;
  assign lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign wmask     = lane_mask[WIDTH-1:0];
  assign wbits     = wdata[WIDTH-1:0] & wmask;

  assign sync_in  = sync_q[SYNC_STAGES-1];
  assign evt      = (pol_q & sync_in & ~prev_in) | (~pol_q & ~sync_in & prev_in);
  assign stat_clr = (wr_en && reg_idx == REG_IRQ_STAT) ? wbits : '0;

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_in <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_in <= sync_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      dir_q <= '0;
      en_q  <= '0;
      pol_q <= '0;
    end else if (wr_en) begin
      case (reg_idx)
        REG_OUT:     out_q <= (out_q & ~wmask) | wbits;
        REG_DIR:     dir_q <= (dir_q & ~wmask) | wbits;
        REG_SET:     out_q <= out_q | wbits;
        REG_CLR:     out_q <= out_q & ~wbits;
        REG_IRQ_EN:  en_q  <= (en_q & ~wmask) | wbits;
        REG_IRQ_POL: pol_q <= (pol_q & ~wmask) | wbits;
        default: ;
      endcase
    end
  end

  // Clear is applied before the OR so a coincident event keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
      irq    <= 1'b0;
    end else begin
      stat_q <= (stat_q & ~stat_clr) | evt;
      irq    <= |(stat_q & en_q);
    end
  end

  always_comb begin
    rd_val = '0;
    if (mapped) begin
      case (reg_idx)
        REG_IN:       rd_val = sync_in;
        REG_OUT:      rd_val = out_q;
        REG_DIR:      rd_val = dir_q;
        REG_IRQ_EN:   rd_val = en_q;
        REG_IRQ_POL:  rd_val = pol_q;
        REG_IRQ_STAT: rd_val = stat_q;
        default:      rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= 32'(rd_val);
    end
  end

endmodule
